chan_select_pipe: RTL

//  Parametrised N:1 channel-select stage with a registered, valid/ready-handshaked output.

---
 rtl/chan_select_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/chan_select_pipe.sv
// -----------------------------------------------------------------------------
// chan_select_pipe
//
// Purpose:
//   N:1 channel-select stage with a registered valid/ready output. Each accepted
//   beat selects one of NUM_CH WIDTH-bit channels by in_sel. The result is held
//   in a 2-entry skid buffer, so upstream sees in_ready with no combinational
//   dependence on out_ready. Out-of-range selects emit DEFAULT_VAL, set the
//   beat's err flag, and bump a saturating error counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   flattened channels, ch i = in_data[i*WIDTH +: WIDTH]
//   in_sel     in   channel index for the offered beat
//   in_valid   in   upstream beat offered
//   in_ready   out  stage can accept a beat (buffer not full, not in reset)
//   out_data   out  head entry data
//   out_sel    out  head entry channel index (as given on input)
//   out_err    out  head entry had in_sel >= NUM_CH
//   out_valid  out  head entry valid (buffer not empty)
//   out_ready  in   downstream accepts head entry
//   clr_err    in   synchronous clear of err_cnt, wins over an increment
//   err_cnt    out  saturating count of accepted out-of-range beats
// -----------------------------------------------------------------------------
module chan_select_pipe #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       NUM_CH      = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    parameter int unsigned       ERR_CNT_W   = 8,
    localparam int unsigned      SEL_W       = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    // Occupancy encodings of the 2-entry buffer
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Head entry (drives outputs) and tail entry (second in FIFO order)
    logic [WIDTH-1:0]     h_data_q, h_data_d;
    logic [SEL_W-1:0]     h_sel_q,  h_sel_d;
    logic                 h_err_q,  h_err_d;
    logic [WIDTH-1:0]     t_data_q, t_data_d;
    logic [SEL_W-1:0]     t_sel_q,  t_sel_d;
    logic                 t_err_q,  t_err_d;
    logic [1:0]           cnt_q,    cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Captured form of the incoming beat
    logic [WIDTH-1:0]     cap_data;
    logic                 cap_err;

    logic                 push;
    logic                 pop;

    // ------------------------------------------------------------------
    // Handshake decode: only registered state (plus reset) feeds in_ready
    // ------------------------------------------------------------------
    assign in_ready  = rst_n & (cnt_q != CNT_FULL);
    assign out_valid = (cnt_q != CNT_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Channel select; any index with no matching channel falls back to
    // DEFAULT_VAL and is flagged as an error.
    // ------------------------------------------------------------------
    always_comb begin
        cap_data = DEFAULT_VAL;
        cap_err  = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(in_sel) == i) begin
                cap_data = in_data[i*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer next state. Entries shift toward the head on pop; a new beat
    // lands in the first slot that is free after this edge's pop.
    // ------------------------------------------------------------------
    always_comb begin
        h_data_d = h_data_q;
        h_sel_d  = h_sel_q;
        h_err_d  = h_err_q;
        t_data_d = t_data_q;
        t_sel_d  = t_sel_q;
        t_err_d  = t_err_q;
        cnt_d    = cnt_q;

        unique case (cnt_q)
            CNT_EMPTY: begin
                // pop is impossible here (out_valid=0)
                if (push) begin
                    h_data_d = cap_data;
                    h_sel_d  = in_sel;
                    h_err_d  = cap_err;
                    cnt_d    = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push && pop) begin
                    // head leaves, new beat becomes head, occupancy unchanged
                    h_data_d = cap_data;
                    h_sel_d  = in_sel;
                    h_err_d  = cap_err;
                end else if (push) begin
                    t_data_d = cap_data;
                    t_sel_d  = in_sel;
                    t_err_d  = cap_err;
                    cnt_d    = CNT_FULL;
                end else if (pop) begin
                    cnt_d    = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                // push is impossible here (in_ready=0)
                if (pop) begin
                    h_data_d = t_data_q;
                    h_sel_d  = t_sel_q;
                    h_err_d  = t_err_q;
                    cnt_d    = CNT_ONE;
                end
            end
            default: begin
                cnt_d = CNT_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating out-of-range counter; clear has priority
    // ------------------------------------------------------------------
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (push && cap_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_data_q  <= '0;
            h_sel_q   <= '0;
            h_err_q   <= 1'b0;
            t_data_q  <= '0;
            t_sel_q   <= '0;
            t_err_q   <= 1'b0;
            cnt_q     <= CNT_EMPTY;
            err_cnt_q <= '0;
        end else begin
            h_data_q  <= h_data_d;
            h_sel_q   <= h_sel_d;
            h_err_q   <= h_err_d;
            t_data_q  <= t_data_d;
            t_sel_q   <= t_sel_d;
            t_err_q   <= t_err_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_data = h_data_q;
    assign out_sel  = h_sel_q;
    assign out_err  = h_err_q;
    assign err_cnt  = err_cnt_q;

endmodule
